seq_divider: RTL and testbench
==============================

# seq_divider

Sequential restoring divider for unsigned operands. It computes one quotient bit per clock and uses the same start/ready handshake as the team's sequential shift-add multiplier, so the two blocks can share one arithmetic unit front-end. The block contains its own controller, counter and datapath registers. It sits beside the multiplier as the inverse arithmetic operation.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; a high level starts an operation when the block is idle
- dividend  input  WIDTH  unsigned dividend, sampled in LOAD
- divisor  input  WIDTH  unsigned divisor, sampled in LOAD
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- ready  output  1  high only in IDLE (combinational from state)
- div_by_zero  output  1  registered; set when the last operation had divisor = 0

## Operation
- States:
  - IDLE: ready=1. start=1 → INIT, otherwise stay.
  - INIT: clear the step counter. start=1 → stay. start=0 → LOAD.
  - LOAD: capture dividend into Q and divisor into D. Clear the partial remainder R (WIDTH+1 bits).
    - divisor=0 → IDLE, with quotient=all ones, remainder=dividend, div_by_zero=1.
    - divisor≠0 → STEP, with div_by_zero=0.
  - STEP: one restoring step per cycle:
    - shift {R,Q} left by 1, so that R gets Q's MSB;
    - compute diff = R_shifted − {0,D} at WIDTH+1 bits;
    - if diff is non-negative (MSB=0): R←diff and Q[0]←1; otherwise R←R_shifted and Q[0]←0;
    - increment the counter.
    - On the step where the counter reaches WIDTH−1 → IDLE; otherwise stay.
- Result registers:
  - quotient=Q and remainder=R[WIDTH−1:0].
  - They are visible continuously.
  - They are valid and stable from the first IDLE cycle until the next LOAD.
  - Values during STEP are intermediate and undefined for the user.
- start is ignored in LOAD and STEP.
- The requester must drop start to leave INIT. Holding start high stalls the block in INIT indefinitely.
- Undefined state encodings → IDLE.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, ready=1, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Let edge e0 be the edge that samples start=1 in IDLE, with start low at the next edge:
  - ready goes low after e0;
  - LOAD is entered at e1;
  - STEP is entered at e2;
  - the WIDTH steps execute on edges e3…e(WIDTH+2);
  - ready goes high after e(WIDTH+2), i.e. WIDTH+2 edges after e0.
- Divide by zero: ready goes high after e2, and the results are valid at the same time.
- Each additional cycle that start stays high adds one INIT cycle.
- Back-to-back operation is allowed: start=1 on the first ready cycle starts a new operation with no idle gap.
- Reset asserted mid-STEP: the operation is aborted, all outputs take reset values, and no partial result persists.

## Structure
- Shared package contents:
  - 2-bit state encoding: IDLE=0, INIT=1, LOAD=2, STEP=3;
  - counter width constant, $clog2(WIDTH).
- One sub-module, seq_div_cu:
  - contains the state machine and step counter;
  - outputs: ld_ops, step_en, ready, last_step;
  - input: divisor_zero from the datapath.
- The top level holds the R/Q/D registers and the subtractor.

## Test plan
- WIDTH=8, dividend=100, divisor=7, one-cycle start → quotient=14, remainder=2, div_by_zero=0; ready high exactly 10 edges after the start edge.
- 255/1 → quotient=255, remainder=0. Then 5/9 → quotient=0, remainder=5. Then 200/200 → quotient=1, remainder=0.
- 37/0 → quotient=255, remainder=37, div_by_zero=1, ready after 2 edges. A following 9/3 → quotient=3, remainder=0, div_by_zero cleared.
- start held high for 4 cycles, operands 63/8 → the block stays in INIT for 4 cycles; results 7 r 7 arrive 3 edges later than the one-cycle case. Operands changed during STEP do not alter the result.
- Assert rst in the 4th STEP cycle of 100/7 → ready=1 and quotient=remainder=div_by_zero=0 immediately. A fresh 50/6 → 8 r 2.
- Randomised 1000 operands at WIDTH=8, plus a directed run at WIDTH=16 (65535/255 → 257 r 0) → every result matches dividend = quotient·divisor + remainder with remainder < divisor.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the controller state encoding and the step-counter sizing helper.
// Imported by the controller and the datapath top level.
package seq_divider_pkg;

  // Controller states; all four 2-bit codes are used.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    LOAD = 2'd2,
    STEP = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Step counter width: enough bits to count 0 .. WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_div_cu.sv
// Controller for seq_divider: IDLE/INIT/LOAD/STEP sequencing plus the step counter.
// Latency: start edge -> LOAD after 1 edge, STEP after 2, back to IDLE after WIDTH+2 edges.
// Backpressure: a held start keeps the block parked in INIT; start is ignored in LOAD and STEP.
module seq_div_cu
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic divisor_zero,
  output logic ld_ops,
  output logic step_en,
  output logic ready,
  output logic last_step
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  // Decodes straight from the state register so the datapath acts in the same cycle.
  assign ready     = (state == IDLE);
  assign ld_ops    = (state == LOAD);
  assign step_en   = (state == STEP);
  assign last_step = step_en && (cnt == CNT_W'(WIDTH - 1));

  // State transitions and step counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= INIT;
        end
        INIT: begin
          cnt <= '0;
          // The requester must release start before the operands are captured.
          if (!start) state <= LOAD;
        end
        LOAD: begin
          // A zero divisor is resolved entirely by the datapath load, no steps needed.
          state <= divisor_zero ? IDLE : STEP;
        end
        STEP: begin
          cnt <= cnt + 1'b1;
          if (last_step) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider for unsigned operands, one quotient bit per clock.
// Latency: WIDTH+2 edges from the sampled start edge (2 edges for a zero divisor).
// Backpressure: start/ready handshake; operands are sampled only in LOAD, results held until next LOAD.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ready,
  output logic             div_by_zero
);

  logic             ld_ops;
  logic             step_en;
  logic             last_step;
  logic             divisor_zero;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  // The partial remainder is always below the divisor after a step, so its
  // WIDTH+1-th bit is only ever nonzero in the shifted/difference terms and
  // need not be stored.
  logic [WIDTH-1:0] r_reg;
  logic             dbz_reg;

  logic [WIDTH:0]   r_shifted;
  logic [WIDTH:0]   diff;

  assign divisor_zero = (divisor == '0);

  seq_div_cu #(
    .WIDTH (WIDTH)
  ) u_cu (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .divisor_zero (divisor_zero),
    .ld_ops       (ld_ops),
    .step_en      (step_en),
    .ready        (ready),
    .last_step    (last_step)
  );

  // One restoring step: shift {R,Q} left, then trial-subtract the divisor.
  assign r_shifted = {r_reg, q_reg[WIDTH-1]};
  assign diff      = r_shifted - {1'b0, d_reg};

  // Operand capture on LOAD and quotient/remainder update on each STEP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg   <= '0;
      d_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
    end else if (ld_ops) begin
      if (divisor_zero) begin
        q_reg   <= '1;
        r_reg   <= dividend;
        d_reg   <= '0;
        dbz_reg <= 1'b1;
      end else begin
        q_reg   <= dividend;
        r_reg   <= '0;
        d_reg   <= divisor;
        dbz_reg <= 1'b0;
      end
    end else if (step_en) begin
      if (!diff[WIDTH]) begin
        r_reg <= diff[WIDTH-1:0];
        q_reg <= {q_reg[WIDTH-2:0], 1'b1};
      end else begin
        r_reg <= r_shifted[WIDTH-1:0];
        q_reg <= {q_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk;
  logic        rst;

  logic        start;
  logic [7:0]  dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        ready;
  logic        div_by_zero;

  logic        start16;
  logic [15:0] dividend16;
  logic [15:0] divisor16;
  logic [15:0] quotient16;
  logic [15:0] remainder16;
  logic        ready16;
  logic        div_by_zero16;

  int nvec;
  int nerr;

  seq_divider #(.WIDTH(8)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .ready       (ready),
    .div_by_zero (div_by_zero)
  );

  seq_divider #(.WIDTH(16)) u_dut16 (
    .clk         (clk),
    .rst         (rst),
    .start       (start16),
    .dividend    (dividend16),
    .divisor     (divisor16),
    .quotient    (quotient16),
    .remainder   (remainder16),
    .ready       (ready16),
    .div_by_zero (div_by_zero16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one 8-bit operation with start high for 'hold' sampled edges.
  // Returns edges from the first start edge (e0) until ready is seen high, or -1 on timeout.
  // Operands are scrambled well after LOAD to prove they are not re-sampled.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold, output int edges);
    int n;
    edges    = -1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    for (int i = 1; i < hold; i++) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = hold - 1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == hold + 2) begin
        dividend = 8'hA5;
        divisor  = 8'h0B;
      end
      if (ready) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, output int edges);
    int n;
    edges      = -1;
    dividend16 = a;
    divisor16  = b;
    start16    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready16) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    nvec++;
    if ({ready, quotient, remainder, div_by_zero} !== {1'b1, 8'd0, 8'd0, 1'b0}) begin
      nerr++;
      $display("FAIL reset: rdy=%b q=%0d r=%0d dbz=%b, need rdy=1 q=0 r=0 dbz=0",
               ready, quotient, remainder, div_by_zero);
    end
    nvec++;
    if ({ready16, quotient16, remainder16, div_by_zero16} !== {1'b1, 16'd0, 16'd0, 1'b0}) begin
      nerr++;
      $display("FAIL reset16: rdy=%b q=%0d r=%0d dbz=%b", ready16, quotient16, remainder16, div_by_zero16);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e;
    run8(8'd100, 8'd7, 1, e);
    nvec++;
    if (e !== 10) begin
      nerr++;
      $display("FAIL basic_latency: got %0d edges, need 10", e);
    end
    nvec++;
    if ({quotient, remainder, div_by_zero} !== {8'd14, 8'd2, 1'b0}) begin
      nerr++;
      $display("FAIL basic_100_7: q=%0d r=%0d dbz=%b, need 14 2 0", quotient, remainder, div_by_zero);
    end
    // Results must hold steady while idle.
    repeat (3) @(negedge clk);
    nvec++;
    if ({ready, quotient, remainder} !== {1'b1, 8'd14, 8'd2}) begin
      nerr++;
      $display("FAIL basic_hold: rdy=%b q=%0d r=%0d, need 1 14 2", ready, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    run8(8'd255, 8'd1, 1, e);
    nvec++;
    if ({e[7:0], quotient, remainder} !== {8'd10, 8'd255, 8'd0}) begin
      nerr++;
      $display("FAIL b2b_255_1: e=%0d q=%0d r=%0d, need 10 255 0", e, quotient, remainder);
    end
    run8(8'd5, 8'd9, 1, e);
    nvec++;
    if ({e[7:0], quotient, remainder} !== {8'd10, 8'd0, 8'd5}) begin
      nerr++;
      $display("FAIL b2b_5_9: e=%0d q=%0d r=%0d, need 10 0 5", e, quotient, remainder);
    end
    run8(8'd200, 8'd200, 1, e);
    nvec++;
    if ({e[7:0], quotient, remainder} !== {8'd10, 8'd1, 8'd0}) begin
      nerr++;
      $display("FAIL b2b_200_200: e=%0d q=%0d r=%0d, need 10 1 0", e, quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    int e;
    run8(8'd37, 8'd0, 1, e);
    nvec++;
    if (e !== 2) begin
      nerr++;
      $display("FAIL dbz_latency: got %0d edges, need 2", e);
    end
    nvec++;
    if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd37, 1'b1}) begin
      nerr++;
      $display("FAIL dbz_37_0: q=%0d r=%0d dbz=%b, need 255 37 1", quotient, remainder, div_by_zero);
    end
    run8(8'd9, 8'd3, 1, e);
    nvec++;
    if ({e[7:0], quotient, remainder, div_by_zero} !== {8'd10, 8'd3, 8'd0, 1'b0}) begin
      nerr++;
      $display("FAIL dbz_clear_9_3: e=%0d q=%0d r=%0d dbz=%b, need 10 3 0 0",
               e, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_held_start();
    int e;
    run8(8'd63, 8'd8, 4, e);
    nvec++;
    if (e !== 13) begin
      nerr++;
      $display("FAIL held_latency: got %0d edges, need 13", e);
    end
    nvec++;
    if ({quotient, remainder, div_by_zero} !== {8'd7, 8'd7, 1'b0}) begin
      nerr++;
      $display("FAIL held_63_8: q=%0d r=%0d dbz=%b, need 7 7 0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_reset_mid_step();
    int e;
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);          // e0
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk); // e1..e5: STEP entered at e2, 4th STEP cycle follows e5
    @(negedge clk);
    nvec++;
    if (ready !== 1'b0) begin
      nerr++;
      $display("FAIL midrst_busy: rdy=%b, need 0", ready);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if ({ready, quotient, remainder, div_by_zero} !== {1'b1, 8'd0, 8'd0, 1'b0}) begin
      nerr++;
      $display("FAIL midrst_clear: rdy=%b q=%0d r=%0d dbz=%b, need 1 0 0 0",
               ready, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run8(8'd50, 8'd6, 1, e);
    nvec++;
    if ({e[7:0], quotient, remainder} !== {8'd10, 8'd8, 8'd2}) begin
      nerr++;
      $display("FAIL midrst_50_6: e=%0d q=%0d r=%0d, need 10 8 2", e, quotient, remainder);
    end
  endtask

  task automatic test_random();
    int e;
    logic [7:0] a;
    logic [7:0] b;
    int bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      run8(a, b, 1, e);
      nvec++;
      if (b == 8'd0) begin
        if ({quotient, remainder, div_by_zero} !== {8'd255, a, 1'b1}) begin
          nerr++;
          bad++;
          if (bad < 10)
            $display("FAIL rand_dbz %0d/0: q=%0d r=%0d dbz=%b", a, quotient, remainder, div_by_zero);
        end
      end else begin
        if ((16'(quotient) * 16'(b) + 16'(remainder) !== 16'(a)) || (remainder >= b) ||
            (div_by_zero !== 1'b0) || (e !== 10)) begin
          nerr++;
          bad++;
          if (bad < 10)
            $display("FAIL rand %0d/%0d: q=%0d r=%0d dbz=%b e=%0d", a, b, quotient, remainder, div_by_zero, e);
        end
      end
    end
  endtask

  task automatic test_wide();
    int e;
    run16(16'd65535, 16'd255, e);
    nvec++;
    if ({e[7:0], quotient16, remainder16, div_by_zero16} !== {8'd18, 16'd257, 16'd0, 1'b0}) begin
      nerr++;
      $display("FAIL wide_65535_255: e=%0d q=%0d r=%0d dbz=%b, need 18 257 0 0",
               e, quotient16, remainder16, div_by_zero16);
    end
    run16(16'd50000, 16'd123, e);
    nvec++;
    if ({quotient16, remainder16} !== {16'd406, 16'd62}) begin
      nerr++;
      $display("FAIL wide_50000_123: q=%0d r=%0d, need 406 62", quotient16, remainder16);
    end
  endtask

  initial begin
    nvec       = 0;
    nerr       = 0;
    start      = 1'b0;
    dividend   = '0;
    divisor    = '0;
    start16    = 1'b0;
    dividend16 = '0;
    divisor16  = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_held_start();
    test_reset_mid_step();
    test_random();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
